// File: rtl/ring_xfer_ctrl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ring_xfer_ctrl_pkg : state codes and majority-vote helper for ring_xfer_ctrl
// Rev 1.0
// -----------------------------------------------------------------------------
package ring_xfer_ctrl_pkg;

   localparam int STATE_W = 4;
   localparam int VOTE_W  = 32;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE       = 4'd0,
      ST_LOAD_ADDR  = 4'd1,
      ST_W4DATA     = 4'd2,
      ST_W4_EVT_AMT = 4'd3,
      ST_INC_SAMP   = 4'd4,
      ST_READ       = 4'd5,
      ST_LAST       = 4'd6,
      ST_NEXT_L1A   = 4'd7,
      ST_ABORT      = 4'd8
   } state_e;

   function automatic logic [VOTE_W-1:0] maj3(input logic [VOTE_W-1:0] a,
                                              input logic [VOTE_W-1:0] b,
                                              input logic [VOTE_W-1:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ring_xfer_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ring_xfer_ctrl_if : L1A/ring/event-buffer handshake bundle of ring_xfer_ctrl
// Rev 1.0
// -----------------------------------------------------------------------------
interface ring_xfer_ctrl_if
   import ring_xfer_ctrl_pkg::*;
#(
   parameter int SAMP_W = 7
);
   logic               L1A_BUF_MT;
   logic               RING_AMT;
   logic               EVT_BUF_AFL;
   logic               EVT_BUF_AMT;
   logic [SAMP_W-1:0]  SAMP_MAX;
   logic               LD_ADDR;
   logic               RD;
   logic               NXT_L1A;
   logic               ABORT_EVT;
   logic               TMR_ERR;
   logic [SAMP_W-1:0]  SAMP_CNT;
   logic [STATE_W-1:0] EVT_STATE;

   // master: the transfer controller itself
   modport master (
      input  L1A_BUF_MT, RING_AMT, EVT_BUF_AFL, EVT_BUF_AMT, SAMP_MAX,
      output LD_ADDR, RD, NXT_L1A, ABORT_EVT, TMR_ERR, SAMP_CNT, EVT_STATE
   );

   modport slave (
      output L1A_BUF_MT, RING_AMT, EVT_BUF_AFL, EVT_BUF_AMT, SAMP_MAX,
      input  LD_ADDR, RD, NXT_L1A, ABORT_EVT, TMR_ERR, SAMP_CNT, EVT_STATE
   );
endinterface
`default_nettype wire

// File: rtl/ring_xfer_ctrl_tmr_vote_reg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tmr_vote_reg : register with optional triple copies, majority vote, mismatch
// Rev 1.0
// -----------------------------------------------------------------------------
module tmr_vote_reg
   import ring_xfer_ctrl_pkg::*;
#(
   parameter int W   = 1,
   parameter int TMR = 1
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         err
);

   generate
      if (TMR != 0) begin : g_tmr
         logic [W-1:0] copy_1_q;
         logic [W-1:0] copy_2_q;
         logic [W-1:0] copy_3_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               copy_1_q <= '0;
               copy_2_q <= '0;
               copy_3_q <= '0;
            end else begin
               copy_1_q <= d;
               copy_2_q <= d;
               copy_3_q <= d;
            end
         end

         assign q   = W'(maj3(VOTE_W'(copy_1_q), VOTE_W'(copy_2_q), VOTE_W'(copy_3_q)));
         assign err = (copy_1_q != copy_2_q) || (copy_1_q != copy_3_q);
      end else begin : g_single
         logic [W-1:0] copy_1_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               copy_1_q <= '0;
            end else begin
               copy_1_q <= d;
            end
         end

         assign q   = copy_1_q;
         assign err = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/ring_xfer_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ring_xfer_ctrl : moves one L1A event from the sample ring to the event buffer
// Rev 1.0
// -----------------------------------------------------------------------------
module ring_xfer_ctrl
   import ring_xfer_ctrl_pkg::*;
#(
   parameter int SAMP_W         = 7,
   parameter int WORDS_PER_SAMP = 96,
   parameter int SEQ_W          = 7,
   parameter int TMR            = 1,
   parameter int TO_W           = 12,
   parameter int TIMEOUT        = 4000
)(
   input  logic             CLK,
   input  logic             RST,
   ring_xfer_ctrl_if.master bus
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [SAMP_W-1:0]  smp_q, smp_d;
   logic [SEQ_W-1:0]   seq_q, seq_d;
   logic [TO_W-1:0]    timer_q, timer_d;
   logic [3:0]         pulse_q, pulse_d;
   logic [4:0]         err;
   logic               tmr_err_q, tmr_err_d;
   logic               wait_cur, wait_nxt, timed_out;

   always_comb begin
      state_d   = ST_IDLE;
      wait_cur  = (state_q == ST_W4DATA) || (state_q == ST_W4_EVT_AMT);
      timed_out = (TIMEOUT != 0) && wait_cur && (timer_q == TO_W'(TIMEOUT - 1));

      case (state_q)
         ST_IDLE:       state_d = bus.L1A_BUF_MT ? ST_IDLE : ST_LOAD_ADDR;
         ST_LOAD_ADDR:  state_d = ST_W4DATA;
         ST_W4DATA: begin
            if (!bus.RING_AMT && bus.EVT_BUF_AFL) state_d = ST_W4_EVT_AMT;
            else if (!bus.RING_AMT)               state_d = ST_INC_SAMP;
            else                                  state_d = ST_W4DATA;
         end
         ST_W4_EVT_AMT: state_d = bus.EVT_BUF_AMT ? ST_INC_SAMP : ST_W4_EVT_AMT;
         ST_INC_SAMP:   state_d = ST_READ;
         ST_READ:       state_d = (seq_q == SEQ_W'(WORDS_PER_SAMP - 2)) ? ST_LAST : ST_READ;
         ST_LAST: begin
            if (smp_q == bus.SAMP_MAX) state_d = ST_NEXT_L1A;
            else if (bus.EVT_BUF_AFL)  state_d = ST_W4_EVT_AMT;
            else if (bus.RING_AMT)     state_d = ST_W4DATA;
            else                       state_d = ST_INC_SAMP;
         end
         ST_NEXT_L1A:   state_d = ST_IDLE;
         ST_ABORT:      state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase

      // a stalled event is dropped regardless of what the inputs ask for
      if (timed_out) begin
         state_d = ST_ABORT;
      end

      // timer survives hops between the two wait states
      wait_nxt = (state_d == ST_W4DATA) || (state_d == ST_W4_EVT_AMT);
      timer_d  = (wait_cur && wait_nxt) ? timer_q + 1'b1 : '0;

      smp_d = smp_q;
      if ((state_d == ST_IDLE) || (state_d == ST_LOAD_ADDR)) begin
         smp_d = '1;
      end else if (state_d == ST_INC_SAMP) begin
         smp_d = smp_q + 1'b1;
      end

      seq_d = '0;
      if ((state_d == ST_READ) || (state_d == ST_LAST)) begin
         seq_d = seq_q + 1'b1;
      end

      pulse_d[3] = (state_d == ST_LOAD_ADDR);
      pulse_d[2] = (state_d == ST_INC_SAMP) || (state_d == ST_READ) || (state_d == ST_LAST);
      pulse_d[1] = (state_d == ST_NEXT_L1A) || (state_d == ST_ABORT);
      pulse_d[0] = (state_d == ST_ABORT);

      tmr_err_d = |err;
   end

   tmr_vote_reg #(.W(STATE_W), .TMR(TMR)) u_state (
      .clk (CLK), .rst (RST), .d (state_d), .q (state_q), .err (err[0])
   );

   tmr_vote_reg #(.W(SAMP_W), .TMR(TMR)) u_smp (
      .clk (CLK), .rst (RST), .d (smp_d), .q (smp_q), .err (err[1])
   );

   tmr_vote_reg #(.W(SEQ_W), .TMR(TMR)) u_seq (
      .clk (CLK), .rst (RST), .d (seq_d), .q (seq_q), .err (err[2])
   );

   tmr_vote_reg #(.W(TO_W), .TMR(TMR)) u_timer (
      .clk (CLK), .rst (RST), .d (timer_d), .q (timer_q), .err (err[3])
   );

   tmr_vote_reg #(.W(4), .TMR(TMR)) u_pulse (
      .clk (CLK), .rst (RST), .d (pulse_d), .q (pulse_q), .err (err[4])
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         tmr_err_q <= 1'b0;
      end else begin
         tmr_err_q <= tmr_err_d;
      end
   end

   assign bus.LD_ADDR   = pulse_q[3];
   assign bus.RD        = pulse_q[2];
   assign bus.NXT_L1A   = pulse_q[1];
   assign bus.ABORT_EVT = pulse_q[0];
   assign bus.TMR_ERR   = tmr_err_q;
   assign bus.SAMP_CNT  = smp_q;
   assign bus.EVT_STATE = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_xfer_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_ring_xfer_ctrl : directed and randomized event transfers against a
// transaction-level expectation (word counts, timing, sample indices)
// -----------------------------------------------------------------------------
module tb_ring_xfer_ctrl;
   import ring_xfer_ctrl_pkg::*;

   localparam int SAMP_W  = 7;
   localparam int WPS     = 96;
   localparam int TIMEOUT = 100;

   localparam int M_QUIET = 0;
   localparam int M_RING  = 1;
   localparam int M_AFL   = 2;
   localparam int M_TMO   = 3;
   localparam int M_RAND  = 4;
   localparam int M_SEU   = 5;
   localparam int M_RST   = 6;

   logic clk = 1'b0;
   logic rst;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int ev_rd, ev_first_rd, ev_last_rd, ev_run, ev_run_bad, ev_idx_bad;
   int ev_nxt, ev_nxt_cyc, ev_nxt_smp, ev_abort, ev_abort_cyc, ev_ld, ev_ld_cyc;

   ring_xfer_ctrl_if #(.SAMP_W(SAMP_W)) bus ();

   ring_xfer_ctrl #(
      .SAMP_W(SAMP_W), .WORDS_PER_SAMP(WPS), .SEQ_W(7),
      .TMR(1), .TO_W(12), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_ev();
      ev_rd = 0; ev_first_rd = -1; ev_last_rd = -1; ev_run = 0;
      ev_run_bad = 0; ev_idx_bad = 0;
      ev_nxt = 0; ev_nxt_cyc = -1; ev_nxt_smp = -1;
      ev_abort = 0; ev_abort_cyc = -1; ev_ld = 0; ev_ld_cyc = -1;
   endtask

   // one clock; outputs observed 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      if (bus.LD_ADDR) begin ev_ld++; ev_ld_cyc = cyc; end
      if (bus.RD) begin
         if (int'(bus.SAMP_CNT) != ev_rd / WPS) ev_idx_bad++;
         if (ev_first_rd < 0) ev_first_rd = cyc;
         ev_last_rd = cyc;
         ev_rd++;
         ev_run++;
      end else if (ev_run > 0) begin
         if (ev_run % WPS != 0) ev_run_bad++;
         ev_run = 0;
      end
      if (bus.NXT_L1A) begin ev_nxt++; ev_nxt_cyc = cyc; ev_nxt_smp = int'(bus.SAMP_CNT); end
      if (bus.ABORT_EVT) begin ev_abort++; ev_abort_cyc = cyc; end
   endtask

   task automatic run_event(input int mode, input int smp_max);
      int    t0, limit, l_cyc, exp_rd;
      bit    done;
      string p;
      p = $sformatf("m%0d_s%0d_", mode, smp_max);
      clear_ev();
      bus.SAMP_MAX    = smp_max[SAMP_W-1:0];
      bus.RING_AMT    = (mode == M_RING) || (mode == M_TMO);
      bus.EVT_BUF_AFL = 1'b0;
      bus.EVT_BUF_AMT = 1'b0;
      bus.L1A_BUF_MT  = 1'b0;
      t0     = cyc;
      l_cyc  = t0 + 3 + 2 * WPS + WPS - 1;
      limit  = (smp_max + 1) * WPS * 4 + 400;
      exp_rd = (smp_max + 1) * WPS;
      done   = 1'b0;
      for (int k = 0; k < limit && !done; k++) begin
         step();
         bus.L1A_BUF_MT = 1'b1;
         if (ev_nxt > 0) done = 1'b1;
         case (mode)
            M_RING: bus.RING_AMT = (cyc <= t0 + 21);
            M_AFL: begin
               if (cyc == l_cyc) begin
                  check({p, "at_last"}, int'(bus.EVT_STATE), int'(ST_LAST));
                  bus.EVT_BUF_AFL = 1'b1;
               end else begin
                  bus.EVT_BUF_AFL = 1'b0;
               end
               if (cyc == l_cyc + 1)  check({p, "w4evt"}, int'(bus.EVT_STATE), int'(ST_W4_EVT_AMT));
               if (cyc == l_cyc + 51) check({p, "resume_rd"}, int'(bus.RD), 1);
               bus.EVT_BUF_AMT = (cyc == l_cyc + 50);
            end
            M_RAND: begin
               bus.RING_AMT    = ($urandom_range(0, 4) == 0);
               bus.EVT_BUF_AFL = ($urandom_range(0, 6) == 0);
               bus.EVT_BUF_AMT = ($urandom_range(0, 2) == 0);
            end
            M_SEU: begin
               if (cyc == t0 + 139) begin
                  check({p, "pre_err"}, int'(bus.TMR_ERR), 0);
                  force dut.u_state.g_tmr.copy_2_q = 4'd9;
                  force dut.u_smp.g_tmr.copy_3_q   = 7'h55;
                  #1;
                  release dut.u_state.g_tmr.copy_2_q;
                  release dut.u_smp.g_tmr.copy_3_q;
               end else if (cyc == t0 + 140) begin
                  check({p, "err_pulse"}, int'(bus.TMR_ERR), 1);
               end else if (cyc == t0 + 141) begin
                  check({p, "err_clear"}, int'(bus.TMR_ERR), 0);
               end
            end
            M_RST: begin
               if (cyc == t0 + 50) begin
                  check({p, "pre_rd"}, int'(bus.RD), 1);
                  rst = 1'b1;
                  step();
                  check({p, "ld"},    int'(bus.LD_ADDR), 0);
                  check({p, "rd"},    int'(bus.RD), 0);
                  check({p, "nxt"},   int'(bus.NXT_L1A), 0);
                  check({p, "abort"}, int'(bus.ABORT_EVT), 0);
                  check({p, "state"}, int'(bus.EVT_STATE), 0);
                  check({p, "smp"},   int'(bus.SAMP_CNT), 0);
                  rst = 1'b0;
                  repeat (300) step();
                  done = 1'b1;
               end
            end
            default: ;
         endcase
      end
      bus.RING_AMT    = 1'b0;
      bus.EVT_BUF_AFL = 1'b0;
      bus.EVT_BUF_AMT = 1'b0;

      if (mode == M_RST) begin
         check({p, "no_nxt"}, ev_nxt, 0);
         return;
      end

      step();
      check({p, "idle_after"}, int'(bus.EVT_STATE), int'(ST_IDLE));
      check({p, "nxt_count"}, ev_nxt, 1);
      check({p, "ld_cyc"}, ev_ld_cyc, t0 + 1);
      check({p, "ld_count"}, ev_ld, 1);
      if (mode == M_TMO) begin
         check({p, "abort_cyc"}, ev_abort_cyc, t0 + 2 + TIMEOUT);
         check({p, "nxt_cyc"}, ev_nxt_cyc, t0 + 2 + TIMEOUT);
         check({p, "abort_count"}, ev_abort, 1);
         check({p, "rd_count"}, ev_rd, 0);
      end else begin
         check({p, "rd_count"}, ev_rd, exp_rd);
         check({p, "abort_count"}, ev_abort, 0);
         check({p, "run_len_bad"}, ev_run_bad, 0);
         check({p, "samp_idx_bad"}, ev_idx_bad, 0);
         check({p, "nxt_after_rd"}, ev_nxt_cyc, ev_last_rd + 1);
         check({p, "nxt_smp"}, ev_nxt_smp, smp_max);
         case (mode)
            M_QUIET, M_SEU: begin
               check({p, "first_rd"}, ev_first_rd, t0 + 3);
               check({p, "span"}, ev_last_rd - ev_first_rd + 1, exp_rd);
            end
            M_RING: begin
               check({p, "first_rd"}, ev_first_rd, t0 + 23);
               check({p, "span"}, ev_last_rd - ev_first_rd + 1, exp_rd);
            end
            M_AFL: begin
               check({p, "first_rd"}, ev_first_rd, t0 + 3);
               check({p, "span"}, ev_last_rd - ev_first_rd + 1, exp_rd + 50);
            end
            default: ;
         endcase
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.L1A_BUF_MT  = 1'b1;
      bus.RING_AMT    = 1'b0;
      bus.EVT_BUF_AFL = 1'b0;
      bus.EVT_BUF_AMT = 1'b0;
      bus.SAMP_MAX    = 7'd7;
      clear_ev();
      repeat (3) step();
      check("rst_ld",      int'(bus.LD_ADDR), 0);
      check("rst_rd",      int'(bus.RD), 0);
      check("rst_nxt",     int'(bus.NXT_L1A), 0);
      check("rst_abort",   int'(bus.ABORT_EVT), 0);
      check("rst_tmr_err", int'(bus.TMR_ERR), 0);
      check("rst_state",   int'(bus.EVT_STATE), 0);
      check("rst_smp",     int'(bus.SAMP_CNT), 0);
      rst = 1'b0;
      step();
      check("idle_state", int'(bus.EVT_STATE), int'(ST_IDLE));
      check("idle_smp_ones", int'(bus.SAMP_CNT), (1 << SAMP_W) - 1);

      run_event(M_QUIET, 7);
      run_event(M_RING, 7);
      run_event(M_AFL, 7);
      run_event(M_TMO, 7);
      run_event(M_SEU, 7);
      run_event(M_RST, 7);
      run_event(M_QUIET, 0);
      for (int i = 0; i < 4; i++) begin
         run_event(M_RAND, int'($urandom_range(0, 4)));
      end
      run_event(M_QUIET, (1 << SAMP_W) - 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
